// File: rtl/reg_status_file.sv
// reg_status_file: architectural register file with per-register rename status.
// ID allocates ROB tags to destination registers and reads sources as value-or-tag.
// ROB commit writes data and releases the status if its tag still owns the register.
// Flush drops all in-flight rename state.
// Optional build macro REG_STATUS_WB_BYPASS_EN: a read sampling a register being
// committed in the same cycle sees the post-commit value and status.
module reg_status_file #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc_en,
    input  logic [REG_W-1:0] alloc_rd,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic [REG_W-1:0] commit_rd,
    input  logic [XLEN-1:0]  commit_data,
    input  logic             rd_req,
    input  logic [REG_W-1:0] rs1_addr,
    input  logic [REG_W-1:0] rs2_addr,
    output logic             rd_valid,
    output logic [XLEN-1:0]  rs1_val,
    output logic [TAG_W-1:0] rs1_tag,
    output logic [XLEN-1:0]  rs2_val,
    output logic [TAG_W-1:0] rs2_tag
);

    localparam logic [TAG_W-1:0] TAG_INVALID = {TAG_W{1'b1}};

`ifdef REG_STATUS_WB_BYPASS_EN
    localparam bit P_BYPASS = 1'b1;
`else
    localparam bit P_BYPASS = 1'b0;
`endif

    logic [XLEN-1:0]  r_regs   [REG_NUM];
    logic [TAG_W-1:0] r_status [REG_NUM];

    logic                  w_commit_vld;
    logic                  w_alloc_vld;
    logic [XLEN+TAG_W-1:0] w_rs1_look;
    logic [XLEN+TAG_W-1:0] w_rs2_look;

    // Source lookup: value and producer tag as seen by a read sampled this cycle.
    // Reads see pre-alloc status; flush forces tags to ready; the bypass build
    // additionally folds in a same-cycle commit to the same register.
    function automatic logic [XLEN+TAG_W-1:0] f_lookup(
        input logic [REG_W-1:0] addr,
        input logic [XLEN-1:0]  reg_val,
        input logic [TAG_W-1:0] reg_st,
        input logic             commit_vld,
        input logic [REG_W-1:0] c_rd,
        input logic [TAG_W-1:0] c_tag,
        input logic [XLEN-1:0]  c_data,
        input logic             flush_i
    );
        logic [XLEN-1:0]  v;
        logic [TAG_W-1:0] t;
        if (addr == {REG_W{1'b0}}) begin
            v = {XLEN{1'b0}};
            t = TAG_INVALID;
        end else if (P_BYPASS && commit_vld && (c_rd == addr)) begin
            v = c_data;
            t = (reg_st == c_tag) ? TAG_INVALID : reg_st;
        end else begin
            v = reg_val;
            t = reg_st;
        end
        if (flush_i) begin
            t = TAG_INVALID;
        end else begin
            t = t;
        end
        return {v, t};
    endfunction

    // Qualify commit and alloc requests; register 0 never changes.
    always_comb begin
        w_commit_vld = (commit_tag != TAG_INVALID) && (commit_rd != {REG_W{1'b0}});
        w_alloc_vld  = alloc_en && (alloc_rd != {REG_W{1'b0}});
    end

    // Combinational read lookup for both source ports.
    always_comb begin
        w_rs1_look = f_lookup(rs1_addr, r_regs[rs1_addr], r_status[rs1_addr],
                              w_commit_vld, commit_rd, commit_tag, commit_data, flush);
        w_rs2_look = f_lookup(rs2_addr, r_regs[rs2_addr], r_status[rs2_addr],
                              w_commit_vld, commit_rd, commit_tag, commit_data, flush);
    end

    // Register data and rename status: commit, then alloc, then flush take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i]   <= {XLEN{1'b0}};
                r_status[i] <= TAG_INVALID;
            end
        end else begin
            if (w_commit_vld) begin
                r_regs[commit_rd] <= commit_data;
            end else begin
                r_regs[commit_rd] <= r_regs[commit_rd];
            end
            for (int i = 1; i < REG_NUM; i++) begin
                if (flush) begin
                    r_status[i] <= TAG_INVALID;
                end else if (w_alloc_vld && (alloc_rd == REG_W'(i))) begin
                    r_status[i] <= alloc_tag;
                end else if (w_commit_vld && (commit_rd == REG_W'(i)) &&
                             (r_status[i] == commit_tag)) begin
                    r_status[i] <= TAG_INVALID;
                end else begin
                    r_status[i] <= r_status[i];
                end
            end
        end
    end

    // Registered read port: capture on rd_req, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rs1_val  <= {XLEN{1'b0}};
            rs1_tag  <= TAG_INVALID;
            rs2_val  <= {XLEN{1'b0}};
            rs2_tag  <= TAG_INVALID;
        end else if (rd_req) begin
            rd_valid <= 1'b1;
            {rs1_val, rs1_tag} <= w_rs1_look;
            {rs2_val, rs2_tag} <= w_rs2_look;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Testbench for reg_status_file: spec-level model plus directed scenarios.
module tb_reg_status_file;

    localparam logic [4:0] INV = 5'h1F;
`ifdef REG_STATUS_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        alloc_en;
    logic [4:0]  alloc_rd;
    logic [4:0]  alloc_tag;
    logic [4:0]  commit_tag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic        rd_req;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rd_valid;
    logic [31:0] rs1_val;
    logic [4:0]  rs1_tag;
    logic [31:0] rs2_val;
    logic [4:0]  rs2_tag;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    reg_status_file dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .commit_tag(commit_tag), .commit_rd(commit_rd), .commit_data(commit_data),
        .rd_req(rd_req), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_valid(rd_valid), .rs1_val(rs1_val), .rs1_tag(rs1_tag),
        .rs2_val(rs2_val), .rs2_tag(rs2_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [32];
    logic [4:0]  m_own  [32];
    logic        e_valid;
    logic [31:0] e_v1, e_v2;
    logic [4:0]  e_t1, e_t2;

    function automatic bit commit_hits(input logic [4:0] a);
        return (commit_tag != INV) && (a != 5'd0) && (commit_rd == a);
    endfunction

    function automatic logic [31:0] model_val(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYP && commit_hits(a)) return commit_data;
        return m_regs[a];
    endfunction

    function automatic logic [4:0] model_tag(input logic [4:0] a);
        if (a == 5'd0 || flush) return INV;
        if (BYP && commit_hits(a) && m_own[a] == commit_tag) return INV;
        return m_own[a];
    endfunction

    // Model state follows the architectural rules at each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= 32'd0;
                m_own[i]  <= INV;
            end
            e_valid <= 1'b0;
            e_v1 <= 32'd0; e_v2 <= 32'd0; e_t1 <= INV; e_t2 <= INV;
        end else begin
            if (rd_req) begin
                e_valid <= 1'b1;
                e_v1 <= model_val(rs1_addr); e_t1 <= model_tag(rs1_addr);
                e_v2 <= model_val(rs2_addr); e_t2 <= model_tag(rs2_addr);
            end else begin
                e_valid <= 1'b0;
            end
            if (commit_hits(commit_rd)) m_regs[commit_rd] <= commit_data;
            for (int i = 1; i < 32; i++) begin
                logic [4:0] t;
                t = m_own[i];
                if (commit_hits(5'(i)) && m_own[i] == commit_tag) t = INV;
                if (alloc_en && alloc_rd == 5'(i)) t = alloc_tag;
                if (flush) t = INV;
                m_own[i] <= t;
            end
        end
    end

    // Compare process: every cycle out of reset, all outputs against the model.
    always @(negedge clk) begin
        if (started && rst_n) begin
            chk("rd_valid", {31'd0, rd_valid}, {31'd0, e_valid});
            chk("rs1_val", rs1_val, e_v1);
            chk("rs1_tag", {27'd0, rs1_tag}, {27'd0, e_t1});
            chk("rs2_val", rs2_val, e_v2);
            chk("rs2_tag", {27'd0, rs2_tag}, {27'd0, e_t2});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        flush = 1'b0; alloc_en = 1'b0; alloc_rd = 5'd0; alloc_tag = 5'd0;
        commit_tag = INV; commit_rd = 5'd0; commit_data = 32'd0;
        rd_req = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic [4:0] tg);
        alloc_en = 1'b1; alloc_rd = rd; alloc_tag = tg; cyc();
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [4:0] tg, input logic [31:0] d);
        commit_rd = rd; commit_tag = tg; commit_data = d; cyc();
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b);
        rd_req = 1'b1; rs1_addr = a; rs2_addr = b; cyc();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_tag", {27'd0, rs1_tag}, {27'd0, INV});
        rst_n = 1'b1;
        started = 1'b1;
        @(negedge clk);

        // allocate then commit r5
        do_alloc(5'd5, 5'd3);
        do_read(5'd5, 5'd0);
        chk("alloc_r5_tag", {27'd0, rs1_tag}, 32'd3);
        chk("r0_tag", {27'd0, rs2_tag}, {27'd0, INV});
        do_commit(5'd5, 5'd3, 32'hDEAD);
        do_read(5'd5, 5'd5);
        chk("commit_r5_val", rs1_val, 32'hDEAD);
        chk("commit_r5_tag", {27'd0, rs2_tag}, {27'd0, INV});
        cyc();
        chk("valid_drop", {31'd0, rd_valid}, 32'd0);
        chk("hold_val", rs1_val, 32'hDEAD);

        // younger producer keeps ownership
        do_alloc(5'd5, 5'd3);
        do_alloc(5'd5, 5'd7);
        do_commit(5'd5, 5'd3, 32'h11);
        do_read(5'd5, 5'd0);
        chk("young_val", rs1_val, 32'h11);
        chk("young_tag", {27'd0, rs1_tag}, 32'd7);

        // register 0 is immutable
        do_alloc(5'd0, 5'd2);
        do_commit(5'd0, 5'd2, 32'hFF);
        do_read(5'd0, 5'd0);
        chk("r0_val", rs1_val, 32'd0);
        chk("r0_tag2", {27'd0, rs1_tag}, {27'd0, INV});

        // flush with same-cycle alloc
        do_alloc(5'd4, 5'd1);
        do_alloc(5'd6, 5'd2);
        do_read(5'd4, 5'd6);
        chk("pre_flush_r4", {27'd0, rs1_tag}, 32'd1);
        chk("pre_flush_r6", {27'd0, rs2_tag}, 32'd2);
        flush = 1'b1; alloc_en = 1'b1; alloc_rd = 5'd7; alloc_tag = 5'd3; cyc();
        do_read(5'd4, 5'd6);
        chk("flush_r4", {27'd0, rs1_tag}, {27'd0, INV});
        chk("flush_r6", {27'd0, rs2_tag}, {27'd0, INV});
        do_read(5'd7, 5'd5);
        chk("flush_r7", {27'd0, rs1_tag}, {27'd0, INV});
        chk("flush_r5_val", rs2_val, 32'h11);

        // read vs same-cycle commit
        do_commit(5'd9, 5'd9, 32'h22);
        do_alloc(5'd9, 5'd4);
        commit_rd = 5'd9; commit_tag = 5'd4; commit_data = 32'h55;
        rd_req = 1'b1; rs1_addr = 5'd9; cyc();
        chk("wb_val", rs1_val, BYP ? 32'h55 : 32'h22);
        chk("wb_tag", {27'd0, rs1_tag}, BYP ? {27'd0, INV} : 32'd4);
        do_read(5'd9, 5'd0);
        chk("wb_after_val", rs1_val, 32'h55);
        chk("wb_after_tag", {27'd0, rs1_tag}, {27'd0, INV});

        // read vs same-cycle alloc sees the older status
        alloc_en = 1'b1; alloc_rd = 5'd10; alloc_tag = 5'd6;
        rd_req = 1'b1; rs1_addr = 5'd10; cyc();
        chk("rd_alloc_tag", {27'd0, rs1_tag}, {27'd0, INV});
        do_read(5'd10, 5'd0);
        chk("rd_alloc_after", {27'd0, rs1_tag}, 32'd6);

        // read vs same-cycle flush
        do_alloc(5'd11, 5'd8);
        flush = 1'b1; rd_req = 1'b1; rs1_addr = 5'd11; rs2_addr = 5'd10; cyc();
        chk("rd_flush_t1", {27'd0, rs1_tag}, {27'd0, INV});
        chk("rd_flush_t2", {27'd0, rs2_tag}, {27'd0, INV});

        // alloc and commit to same register in the same cycle
        do_alloc(5'd12, 5'd5);
        commit_rd = 5'd12; commit_tag = 5'd5; commit_data = 32'h77;
        alloc_en = 1'b1; alloc_rd = 5'd12; alloc_tag = 5'd9; cyc();
        do_read(5'd12, 5'd0);
        chk("ac_val", rs1_val, 32'h77);
        chk("ac_tag", {27'd0, rs1_tag}, 32'd9);

        // mid-run reset with pending tags
        do_alloc(5'd13, 5'd2);
        do_alloc(5'd14, 5'd3);
        do_read(5'd13, 5'd14);
        chk("pend_r13", {27'd0, rs1_tag}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, rd_valid}, 32'd0);
        chk("async_t1", {27'd0, rs1_tag}, {27'd0, INV});
        chk("async_t2", {27'd0, rs2_tag}, {27'd0, INV});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(5'd13, 5'd14);
        chk("rst_r13", {27'd0, rs1_tag}, {27'd0, INV});
        chk("rst_r14", {27'd0, rs2_tag}, {27'd0, INV});
        do_read(5'd5, 5'd12);
        chk("rst_r5_val", rs1_val, 32'd0);
        chk("rst_r12_val", rs2_val, 32'd0);

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
